// File: rtl/fir_seq_ctrl.sv
// Sequencer for the fir datapath: coefficient load, delay-line priming with zeros,
// valid/ready sample streaming through the FIR, and tail flush.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for i_load / i_start
// ST_LOAD  | accepting FIR_LEN coefficient words, tap 0 first
// ST_PRIME | FIR_LEN-1 zero advances to clear the delay line
// ST_RUN   | streaming source samples, one advance per accepted sample
// ST_FLUSH | zero advances pushing the tail of the response out
// ST_DRAIN | waiting for the last tagged output to be taken
module fir_seq_ctrl #(
    parameter int FIR_LEN  = 21,
    parameter int NB_COEFF = 8,
    parameter int NB_IN    = 18,
    parameter int NB_OUT   = 18,
    parameter int FIR_LAT  = 1,
    localparam int AW      = $clog2(FIR_LEN),
    localparam int CW      = $clog2(FIR_LEN + FIR_LAT)
) (
    input  logic                clk,
    input  logic                i_reset,
    input  logic                i_load,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic                i_cfg_valid,
    input  logic [NB_COEFF-1:0] i_cfg_coeff,
    output logic                o_cfg_ready,
    output logic                o_coeff_we,
    output logic [AW-1:0]       o_coeff_addr,
    output logic [NB_COEFF-1:0] o_coeff_data,
    input  logic                i_s_valid,
    input  logic [NB_IN-1:0]    i_s_data,
    output logic                o_s_ready,
    output logic                o_fir_en,
    output logic                o_fir_valid,
    output logic [NB_IN-1:0]    o_fir_data,
    input  logic [NB_OUT-1:0]   i_fir_sample,
    output logic                o_m_valid,
    output logic [NB_OUT-1:0]   o_m_data,
    input  logic                i_m_ready,
    output logic                o_busy,
    output logic                o_done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PRIME,
        ST_RUN,
        ST_FLUSH,
        ST_DRAIN
    } state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [FIR_LAT-1:0] tag, tag_nxt;
    logic               stall;
    logic               m_hs;
    logic               adv;
    logic               push;

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            tag   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            tag   <= tag_nxt;
        end
    end

    assign o_m_valid   = tag[FIR_LAT-1];
    assign o_m_data    = o_m_valid ? i_fir_sample : '0;
    assign stall       = o_m_valid & ~i_m_ready;
    assign m_hs        = o_m_valid & i_m_ready;
    assign o_fir_valid = adv;
    assign o_fir_en    = (state == ST_PRIME) || (state == ST_RUN) ||
                         (state == ST_FLUSH) || (state == ST_DRAIN);
    assign o_busy      = (state != ST_IDLE);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        adv          = 1'b0;
        push         = 1'b0;
        o_cfg_ready  = 1'b0;
        o_coeff_we   = 1'b0;
        o_coeff_addr = '0;
        o_coeff_data = '0;
        o_s_ready    = 1'b0;
        o_fir_data   = '0;
        o_done       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (i_load) begin
                    state_nxt = ST_LOAD;
                    cnt_nxt   = '0;
                end else if (i_start) begin
                    state_nxt = ST_PRIME;
                    cnt_nxt   = CW'(FIR_LEN - 2);
                end
            end
            ST_LOAD: begin
                o_cfg_ready = 1'b1;
                if (i_cfg_valid) begin
                    o_coeff_we   = 1'b1;
                    o_coeff_addr = AW'(cnt);
                    o_coeff_data = i_cfg_coeff;
                    if (cnt == CW'(FIR_LEN - 1)) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            ST_PRIME: begin
                if (i_stop) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    adv = ~stall;
                    if (adv) begin
                        if (cnt == '0) state_nxt = ST_RUN;
                        else           cnt_nxt   = cnt - CW'(1);
                    end
                end
            end
            ST_RUN: begin
                o_s_ready  = ~stall;
                o_fir_data = i_s_data;
                adv        = i_s_valid & ~stall;
                push       = 1'b1;
                if (i_stop) begin
                    state_nxt = ST_FLUSH;
                    cnt_nxt   = CW'(FIR_LEN + FIR_LAT - 3);
                end
            end
            ST_FLUSH: begin
                adv  = ~stall;
                // the final FIR_LAT-1 advances only shift the last real tag to the output
                push = (int'(cnt) + 1 >= FIR_LAT);
                if (adv) begin
                    if (cnt == '0) state_nxt = ST_DRAIN;
                    else           cnt_nxt   = cnt - CW'(1);
                end
            end
            ST_DRAIN: begin
                if (!o_m_valid || i_m_ready) begin
                    state_nxt = ST_IDLE;
                    o_done    = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // An output taken without an advance must not be presented again.
    always_comb begin
        tag_nxt = tag;
        if (adv) begin
            tag_nxt    = tag << 1;
            tag_nxt[0] = push;
        end else if (m_hs) begin
            tag_nxt[FIR_LAT-1] = 1'b0;
        end
        if (state_nxt == ST_IDLE) tag_nxt = '0;
    end

endmodule
